// File: rtl/psr_controller.sv
// psr_controller - 65C02 processor status register (P).
//
// Holds the N V D I Z C flags; X (bit 5) and B (bit 4) are not stored.
// Sources that can change P, in priority order within one cycle:
//   irq_entry > plp_load > ALU capture > flag_op_valid > nz_load
// Only the winning event is applied.
// Losing lower-priority strobes are dropped.
// A losing ALU request is the exception: it stays pending.
//
// ALU handshake (valid/ready semantics):
//   psr_update_request is a level held high by the ALU until it sees
//   ack_update_request. The flags are captured on the edge that moves the
//   FSM IDLE -> ACK, and ack is high for exactly the following cycle.
//   The FSM then waits in WAIT_LOW for the request to drop before it can
//   accept a new one, so a held request is captured only once.
//
// Build option:
//   PSR_CMOS_DCLR_EN defined   : irq_entry sets I and clears D (65C02).
//   PSR_CMOS_DCLR_EN undefined : irq_entry sets I, D is untouched (NMOS).
//
// The handshake state is held in 'state' so that checkers can bind to it.

module psr_controller (
  input  logic       mem_clk,
  input  logic       resb,
  input  logic       psr_update_request,
  input  logic       n_result,
  input  logic       v_result,
  input  logic       z_result,
  input  logic       c_result,
  output logic       ack_update_request,
  input  logic       flag_op_valid,
  input  logic [2:0] flag_op,
  input  logic       plp_load,
  input  logic [7:0] db_in,
  input  logic       nz_load,
  input  logic [7:0] nz_value,
  input  logic       irq_entry,
  input  logic       push_brk,
  output logic [7:0] psr_to_id,
  output logic [7:0] psr_push,
  output logic       c_carry,
  output logic       d_decimal
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  localparam logic [2:0] OP_CLC = 3'd0;
  localparam logic [2:0] OP_SEC = 3'd1;
  localparam logic [2:0] OP_CLI = 3'd2;
  localparam logic [2:0] OP_SEI = 3'd3;
  localparam logic [2:0] OP_CLD = 3'd4;
  localparam logic [2:0] OP_SED = 3'd5;
  localparam logic [2:0] OP_CLV = 3'd6;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic n_flag, v_flag, d_flag, i_flag, z_flag, c_flag;
  logic n_nxt,  v_nxt,  d_nxt,  i_nxt,  z_nxt,  c_nxt;

  // An ALU capture happens only from IDLE and only when no higher-priority
  // event claims the cycle; otherwise the request simply stays pending.
  logic alu_capture;
  assign alu_capture = (state == ST_IDLE) && psr_update_request &&
                       !irq_entry && !plp_load;

  // Handshake FSM next-state logic.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:     state_nxt = alu_capture ? ST_ACK : ST_IDLE;
      ST_ACK:      state_nxt = psr_update_request ? ST_WAIT_LOW : ST_IDLE;
      ST_WAIT_LOW: state_nxt = psr_update_request ? ST_WAIT_LOW : ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Handshake FSM state register; reset forces IDLE at once, so a request
  // still held after reset is treated as a new one.
  always_ff @(posedge mem_clk or posedge resb) begin
    if (resb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flag next-value selection: the first active event in priority order wins.
  always_comb begin
    n_nxt = n_flag;
    v_nxt = v_flag;
    d_nxt = d_flag;
    i_nxt = i_flag;
    z_nxt = z_flag;
    c_nxt = c_flag;
    if (irq_entry) begin
      i_nxt = 1'b1;
`ifdef PSR_CMOS_DCLR_EN
      d_nxt = 1'b0;
`else
      d_nxt = d_flag;
`endif
    end else if (plp_load) begin
      // Bits 5 (X) and 4 (B) of the pulled byte have no storage.
      n_nxt = db_in[7];
      v_nxt = db_in[6];
      d_nxt = db_in[3];
      i_nxt = db_in[2];
      z_nxt = db_in[1];
      c_nxt = db_in[0];
    end else if (alu_capture) begin
      n_nxt = n_result;
      v_nxt = v_result;
      z_nxt = z_result;
      c_nxt = c_result;
    end else if (flag_op_valid) begin
      case (flag_op)
        OP_CLC:  c_nxt = 1'b0;
        OP_SEC:  c_nxt = 1'b1;
        OP_CLI:  i_nxt = 1'b0;
        OP_SEI:  i_nxt = 1'b1;
        OP_CLD:  d_nxt = 1'b0;
        OP_SED:  d_nxt = 1'b1;
        OP_CLV:  v_nxt = 1'b0;
        default: ; // code 7: no flag changes
      endcase
    end else if (nz_load) begin
      n_nxt = nz_value[7];
      z_nxt = (nz_value == 8'h00);
    end
  end

  // Flag registers; reset leaves interrupts masked and decimal mode off.
  always_ff @(posedge mem_clk or posedge resb) begin
    if (resb) begin
      n_flag <= 1'b0;
      v_flag <= 1'b0;
      d_flag <= 1'b0;
      i_flag <= 1'b1;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
    end else begin
      n_flag <= n_nxt;
      v_flag <= v_nxt;
      d_flag <= d_nxt;
      i_flag <= i_nxt;
      z_flag <= z_nxt;
      c_flag <= c_nxt;
    end
  end

  // Output views of P; ack is a pure decode of the ACK state.
  always_comb begin
    ack_update_request = (state == ST_ACK);
    psr_to_id = {n_flag, v_flag, 1'b1, 1'b1,     d_flag, i_flag, z_flag, c_flag};
    psr_push  = {n_flag, v_flag, 1'b1, push_brk, d_flag, i_flag, z_flag, c_flag};
    c_carry   = c_flag;
    d_decimal = d_flag;
  end

endmodule

// File: tb/tb_psr_controller.sv
// tb_psr_controller - directed self-checking bench for psr_controller.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge that sampled the stimulus.
// Compile with +define+PSR_CMOS_DCLR_EN to exercise the 65C02 build.

module tb_psr_controller;

  logic       mem_clk;
  logic       resb;
  logic       psr_update_request;
  logic       n_result, v_result, z_result, c_result;
  logic       ack_update_request;
  logic       flag_op_valid;
  logic [2:0] flag_op;
  logic       plp_load;
  logic [7:0] db_in;
  logic       nz_load;
  logic [7:0] nz_value;
  logic       irq_entry;
  logic       push_brk;
  logic [7:0] psr_to_id;
  logic [7:0] psr_push;
  logic       c_carry;
  logic       d_decimal;

  int errors = 0;
  int checks = 0;

  psr_controller dut (
    .mem_clk            (mem_clk),
    .resb               (resb),
    .psr_update_request (psr_update_request),
    .n_result           (n_result),
    .v_result           (v_result),
    .z_result           (z_result),
    .c_result           (c_result),
    .ack_update_request (ack_update_request),
    .flag_op_valid      (flag_op_valid),
    .flag_op            (flag_op),
    .plp_load           (plp_load),
    .db_in              (db_in),
    .nz_load            (nz_load),
    .nz_value           (nz_value),
    .irq_entry          (irq_entry),
    .push_brk           (push_brk),
    .psr_to_id          (psr_to_id),
    .psr_push           (psr_push),
    .c_carry            (c_carry),
    .d_decimal          (d_decimal)
  );

  // Clock: 10 time-unit period.
  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic req, input logic n, input logic v,
                         input logic z, input logic c);
    psr_update_request = req;
    n_result = n;
    v_result = v;
    z_result = z;
    c_result = c;
  endtask

  logic [7:0] exp_irq;

  initial begin
    resb = 1'b1;
    set_alu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flag_op_valid = 1'b0;
    flag_op       = 3'd7;
    plp_load      = 1'b0;
    db_in         = 8'h00;
    nz_load       = 1'b0;
    nz_value      = 8'h00;
    irq_entry     = 1'b0;
    push_brk      = 1'b0;

    // Reset state
    step();
    step();
    check("reset_psr", psr_to_id, 8'h34);
    check("reset_ack", {7'd0, ack_update_request}, 8'h00);
    check("reset_cd", {6'd0, c_carry, d_decimal}, 8'h00);
    resb = 1'b0;
    step();
    check("idle_psr", psr_to_id, 8'h34);

    // SED
    flag_op_valid = 1'b1; flag_op = 3'd5;
    step();
    flag_op_valid = 1'b0;
    check("sed_psr", psr_to_id, 8'h3C);
    check("sed_d", {7'd0, d_decimal}, 8'h01);

    // Interrupt entry: D clear only in the CMOS build
`ifdef PSR_CMOS_DCLR_EN
    exp_irq = 8'h34;
`else
    exp_irq = 8'h3C;
`endif
    irq_entry = 1'b1;
    step();
    irq_entry = 1'b0;
    check("irq_psr", psr_to_id, exp_irq);

    // CLD for a known starting point; code 7 changes nothing
    flag_op_valid = 1'b1; flag_op = 3'd4;
    step();
    check("cld_psr", psr_to_id, 8'h34);
    flag_op = 3'd7;
    step();
    flag_op_valid = 1'b0;
    check("nop_op_psr", psr_to_id, 8'h34);

    // Held ALU request 1/1/0/1: single capture, single-cycle ack
    set_alu(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("alu_cap_psr", psr_to_id, 8'hF5);
    check("alu_cap_ack", {7'd0, ack_update_request}, 8'h01);
    set_alu(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("alu_hold1_ack", {7'd0, ack_update_request}, 8'h00);
    check("alu_hold1_psr", psr_to_id, 8'hF5);
    step();
    check("alu_hold2_psr", psr_to_id, 8'hF5);
    step();
    check("alu_hold3_psr", psr_to_id, 8'hF5);
    check("alu_hold3_ack", {7'd0, ack_update_request}, 8'h00);
    set_alu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("alu_release_ack", {7'd0, ack_update_request}, 8'h00);

    // Request and PLP together: PLP wins, ALU captured next cycle
    set_alu(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    plp_load = 1'b1; db_in = 8'hC3;
    step();
    plp_load = 1'b0;
    check("plp_psr", psr_to_id, 8'hF3);
    check("plp_ack", {7'd0, ack_update_request}, 8'h00);
    step();
    check("pend_cap_psr", psr_to_id, 8'h70);
    check("pend_cap_ack", {7'd0, ack_update_request}, 8'h01);
    set_alu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("pend_done_ack", {7'd0, ack_update_request}, 8'h00);

    // SEC, then N/Z loads leave C alone
    flag_op_valid = 1'b1; flag_op = 3'd1;
    step();
    flag_op_valid = 1'b0;
    check("sec_psr", psr_to_id, 8'h71);
    nz_load = 1'b1; nz_value = 8'h00;
    step();
    check("nz00_psr", psr_to_id, 8'h73);
    nz_value = 8'h80;
    step();
    nz_load = 1'b0;
    check("nz80_psr", psr_to_id, 8'hF1);
    check("nz80_c", {7'd0, c_carry}, 8'h01);

    // PLP 05 -> P=35, then psr_push with both B values
    plp_load = 1'b1; db_in = 8'h05;
    step();
    plp_load = 1'b0;
    check("plp35_psr", psr_to_id, 8'h35);
    push_brk = 1'b0;
    #1;
    check("push_b0", psr_push, 8'h25);
    push_brk = 1'b1;
    #1;
    check("push_b1", psr_push, 8'h35);
    push_brk = 1'b0;

    // flag_op beats nz_load in the same cycle (CLC only, N untouched)
    flag_op_valid = 1'b1; flag_op = 3'd0;
    nz_load = 1'b1; nz_value = 8'h80;
    step();
    flag_op_valid = 1'b0; nz_load = 1'b0;
    check("op_over_nz_psr", psr_to_id, 8'h34);

    // Reset while in ACK: ack drops immediately, held request recaptured
    set_alu(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_rst_ack", {7'd0, ack_update_request}, 8'h01);
    check("pre_rst_psr", psr_to_id, 8'hB4);
    resb = 1'b1;
    #1;
    check("rst_ack_drop", {7'd0, ack_update_request}, 8'h00);
    check("rst_psr", psr_to_id, 8'h34);
    step();
    resb = 1'b0;
    step();
    check("post_rst_ack", {7'd0, ack_update_request}, 8'h01);
    check("post_rst_psr", psr_to_id, 8'hB4);
    set_alu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_rst_done_ack", {7'd0, ack_update_request}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
